// File: rtl/alu_if.sv
// Execute-stage ALU bus: operands and opcode in, registered result and zero flag out.
interface alu_if;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_op;
  logic [31:0] result;
  logic        zero;

  modport master (output op1, output op2, output alu_op, input result, input zero);
  modport slave  (input op1, input op2, input alu_op, output result, output zero);
endinterface

// File: rtl/alu.sv
// 32-bit RISC-V execute-stage ALU with registered result and zero flag, one-cycle latency.
module alu (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SLT = 4'b0100,
    OP_XOR = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRL = 4'b1000,
    OP_SLL = 4'b1001,
    OP_SRA = 4'b1010
  } alu_op_e;

  logic [31:0] next_result;
  logic [4:0]  shamt;

  assign shamt = bus.op2[4:0];

  always_comb begin
    next_result = '0;
    case (alu_op_e'(bus.alu_op))
      OP_AND:  next_result = bus.op1 & bus.op2;
      OP_OR:   next_result = bus.op1 | bus.op2;
      OP_ADD:  next_result = bus.op1 + bus.op2;
      OP_SUB:  next_result = bus.op1 - bus.op2;
      OP_SLT:  next_result = ($signed(bus.op1) < $signed(bus.op2)) ? 32'd1 : 32'd0;
      OP_XOR:  next_result = bus.op1 ^ bus.op2;
      OP_SRL:  next_result = bus.op1 >> shamt;
      OP_SLL:  next_result = bus.op1 << shamt;
      OP_SRA:  next_result = $unsigned($signed(bus.op1) >>> shamt);
      default: next_result = '0;
    endcase
  end

  // zero is derived from next_result so it always matches the registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result <= '0;
      bus.zero   <= 1'b1;
    end else begin
      bus.result <= next_result;
      bus.zero   <= (next_result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected values queued at drive time, compared one cycle later.
module tb_alu;

  logic clk = 1'b0;
  logic rst;

  alu_if bus_if ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0101: return a ^ b;
      4'b1000: return a >> sh;
      4'b1001: return a << sh;
      4'b1010: return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle of stimulus and queue what should appear after the next edge
  task automatic send(input string tag, input logic r, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus_if.alu_op = op;
    bus_if.op1    = a;
    bus_if.op2    = b;
    e.tag = tag;
    e.res = exp_res;
    e.z   = (exp_res == 32'd0);
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".result"}, bus_if.result, e.res);
        check({e.tag, ".zero"}, {31'd0, bus_if.zero}, {31'd0, e.z});
      end
    end
  end

  initial begin
    logic [3:0] ops [10];
    logic [3:0] op;
    logic [31:0] a, b;
    int unsigned waited;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100,
            4'b0101, 4'b1000, 4'b1001, 4'b1010, 4'b1111};

    rst = 1'b1;
    bus_if.alu_op = 4'b0010;
    bus_if.op1 = 32'h1234_5678;
    bus_if.op2 = 32'h0000_0001;

    send("rst0", 1'b1, 4'b0010, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000);
    send("rst1", 1'b1, 4'b0001, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000);

    send("and",  1'b0, 4'b0000, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000);
    send("or",   1'b0, 4'b0001, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
    send("xor",  1'b0, 4'b0101, 32'h1234_5678, 32'h8765_4321, 32'h9551_1559);
    send("add",  1'b0, 4'b0010, 32'd20, 32'd22, 32'h0000_002A);
    send("sub",  1'b0, 4'b0110, 32'd50, 32'd30, 32'h0000_0014);
    send("sub0", 1'b0, 4'b0110, 32'd5, 32'd5, 32'h0000_0000);
    send("addw", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
    send("slt1", 1'b0, 4'b0100, 32'd10, 32'd20, 32'h0000_0001);
    send("slt0", 1'b0, 4'b0100, 32'd20, 32'd10, 32'h0000_0000);
    send("slts", 1'b0, 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001);
    send("srl",  1'b0, 4'b1000, 32'hFFFF_FFFF, 32'd4, 32'h0FFF_FFFF);
    send("sll",  1'b0, 4'b1001, 32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFF0);
    send("sra",  1'b0, 4'b1010, 32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFF);
    send("sram", 1'b0, 4'b1010, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    send("srl0", 1'b0, 4'b1000, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF);
    send("bad",  1'b0, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    send("pre",  1'b0, 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
    send("rstm", 1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000);
    send("post", 1'b0, 4'b0010, 32'd1, 32'd2, 32'h0000_0003);

    for (int unsigned i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      send("rand", 1'b0, op, a, b, model(op, a, b));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("drain", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
